// File: rtl/onchip_mem_stream_reader_if.sv
// Memory read-master bus plus Avalon-ST source bundled for the stream reader.
interface onchip_mem_stream_reader_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Reads a contiguous byte run from on-chip memory and streams it out on an
// Avalon-ST source; a small output buffer hides the 1-cycle read latency.
module onchip_mem_stream_reader #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_WORDS  = 409600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  onchip_mem_stream_reader_if.master bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clken_q;

  // Request stage: chipselect/address plus sop/eop tags travelling with the read
  logic              cs_q, cs_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              req_sop_q, req_sop_d;
  logic              req_eop_q, req_eop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;

  // Return stage: memory data is valid the cycle after the request
  logic              rd_pend_q, rd_pend_d;
  logic              rd_sop_q, rd_sop_d;
  logic              rd_eop_q, rd_eop_d;

  // Output head register backed by a small circular buffer
  entry_t            head_q, head_d;
  logic              head_valid_q, head_valid_d;
  entry_t            buf_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;

  logic              pop, push, head_free, buf_we, buf_pop, can_issue;
  entry_t            push_entry;
  logic [OCC_W-1:0]  occ_q, occ_next;

  // Next-state, request issue and buffer control
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    cs_d         = 1'b0;
    addr_out_d   = addr_out_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    req_sop_d    = 1'b0;
    req_eop_d    = 1'b0;
    rd_pend_d    = cs_q;
    rd_sop_d     = req_sop_q;
    rd_eop_d     = req_eop_q;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    buf_pop      = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    pop        = head_valid_q & bus.src_ready;
    push       = rd_pend_q;
    push_entry = '{sop: rd_sop_q, eop: rd_eop_q, data: bus.mem_readdata};
    head_free  = ~head_valid_q | pop;

    if (head_free) begin
      if (bcnt_q != '0) begin
        head_d       = buf_q[rd_ptr_q];
        head_valid_d = 1'b1;
        buf_pop      = 1'b1;
      end else if (push) begin
        head_d       = push_entry;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end
    buf_we = push & ~(head_free & (bcnt_q == '0));

    // Space check covers the byte returning now and the read already on the bus
    occ_q     = OCC_W'(bcnt_q) + OCC_W'(head_valid_q);
    occ_next  = occ_q + OCC_W'(push) - OCC_W'(pop);
    can_issue = (occ_next + OCC_W'(cs_q)) < OCC_W'(FIFO_DEPTH);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            cs_d        = 1'b1;
            addr_out_d  = start_addr;
            addr_d      = next_addr(start_addr);
            remaining_d = length - ADDR_W'(1);
            req_sop_d   = 1'b1;
            req_eop_d   = (length == ADDR_W'(1));
            state_d     = (length == ADDR_W'(1)) ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (can_issue) begin
          cs_d        = 1'b1;
          addr_out_d  = addr_q;
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - ADDR_W'(1);
          req_eop_d   = (remaining_q == ADDR_W'(1));
          if (remaining_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!cs_q && !rd_pend_q && (occ_next == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      done_d       = 1'b1;
      cs_d         = 1'b0;
      addr_out_d   = addr_out_q;
      req_sop_d    = 1'b0;
      req_eop_d    = 1'b0;
      rd_pend_d    = 1'b0;
      head_valid_d = 1'b0;
      buf_we       = 1'b0;
      buf_pop      = 1'b0;
    end

    if (buf_we)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (buf_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    bcnt_d = bcnt_q + CNT_W'(buf_we) - CNT_W'(buf_pop);
    if (abort && (state_q != IDLE)) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      bcnt_d   = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      clken_q      <= 1'b0;
      cs_q         <= 1'b0;
      addr_out_q   <= '0;
      req_sop_q    <= 1'b0;
      req_eop_q    <= 1'b0;
      addr_q       <= '0;
      remaining_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      bcnt_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      clken_q      <= 1'b1;
      cs_q         <= cs_d;
      addr_out_q   <= addr_out_d;
      req_sop_q    <= req_sop_d;
      req_eop_q    <= req_eop_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      rd_pend_q    <= rd_pend_d;
      rd_sop_q     <= rd_sop_d;
      rd_eop_q     <= rd_eop_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      bcnt_q       <= bcnt_d;
      if (buf_we) buf_q[wr_ptr_q] <= push_entry;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign bus.mem_address    = addr_out_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_writedata  = '0;
  assign bus.mem_clken      = clken_q;
  assign bus.src_valid      = head_valid_q;
  assign bus.src_data       = head_q.data;
  assign bus.src_sop        = head_q.sop;
  assign bus.src_eop        = head_q.eop;

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench for onchip_mem_stream_reader: memory returns address low byte.
module tb_onchip_mem_stream_reader;

  localparam int MEM_WORDS = 409600;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [18:0] start_addr;
  logic [18:0] length;
  logic        abort;
  logic        busy;
  logic        done;

  onchip_mem_stream_reader_if #(.ADDR_W(19), .DATA_W(8)) bus ();

  onchip_mem_stream_reader #(
    .ADDR_W(19), .DATA_W(8), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  exp_t        exp_q[$];
  logic [18:0] addr_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word content is the address low byte, one-cycle latency
  always @(posedge clk) begin
    if (bus.mem_chipselect) begin
      bus.mem_readdata <= bus.mem_address[7:0];
      addr_log.push_back(bus.mem_address);
    end else begin
      bus.mem_readdata <= 8'hEE;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL %s_ctrl busy/done=%b required 00", tag, {busy, done});
    end
    n_tests++;
    if ({bus.mem_chipselect, bus.mem_address, bus.mem_write, bus.mem_writedata, bus.mem_clken} !== '0) begin
      n_fail++;
      $display("FAIL %s_mem cs=%b addr=%h wr=%b wdata=%h clken=%b required all 0", tag,
               bus.mem_chipselect, bus.mem_address, bus.mem_write, bus.mem_writedata, bus.mem_clken);
    end
    n_tests++;
    if ({bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data} !== '0) begin
      n_fail++;
      $display("FAIL %s_src valid=%b sop=%b eop=%b data=%h required all 0", tag,
               bus.src_valid, bus.src_sop, bus.src_eop, bus.src_data);
    end
  endtask

  // Runs one transfer; mode 0: sink always ready, mode 1: ready one cycle in three
  task automatic stream_run(input logic [18:0] a, input logic [18:0] len, input int mode,
                            output int first_c, output int last_c, output int done_c,
                            output int gaps, output bit stall_seen);
    int         budget;
    exp_t       e;
    bit         held;
    logic [9:0] held_v;
    budget = 40 + 4 * int'(len);
    addr_log.delete();
    for (int i = 0; i < int'(len); i++) begin
      e.sop  = (i == 0);
      e.eop  = (i == int'(len) - 1);
      e.data = 8'((int'(a) + i) % MEM_WORDS);
      exp_q.push_back(e);
    end
    first_c = -1; last_c = -1; done_c = -1; gaps = 0; stall_seen = 1'b0; held = 1'b0;
    held_v = '0;
    @(negedge clk);
    start = 1'b1; start_addr = a; length = len; bus.src_ready = (mode == 0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      bus.src_ready = (mode == 0) || (c % 3 == 0);
      if (c == 1) begin
        n_tests++;
        if ({busy, bus.mem_chipselect} !== 2'b11 || bus.mem_address !== a) begin
          n_fail++;
          $display("FAIL first_issue busy=%b cs=%b addr=%0d required busy=1 cs=1 addr=%0d",
                   busy, bus.mem_chipselect, bus.mem_address, a);
        end
      end
      if (c > 1 && busy && !bus.mem_chipselect && addr_log.size() < int'(len)) stall_seen = 1'b1;
      if (held) begin
        n_tests++;
        if (!bus.src_valid || {bus.src_sop, bus.src_eop, bus.src_data} !== held_v) begin
          n_fail++;
          $display("FAIL stall_stable valid=%b got=%h required=%h", bus.src_valid,
                   {bus.src_sop, bus.src_eop, bus.src_data}, held_v);
        end
      end
      held   = bus.src_valid && !bus.src_ready;
      held_v = {bus.src_sop, bus.src_eop, bus.src_data};
      if (bus.src_valid && first_c < 0) first_c = c;
      if (bus.src_valid && bus.src_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_byte got=%h required none", {bus.src_sop, bus.src_eop, bus.src_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.src_sop, bus.src_eop, bus.src_data} !== e) begin
            n_fail++;
            $display("FAIL byte sop/eop/data got=%b/%b/%h required %b/%b/%h",
                     bus.src_sop, bus.src_eop, bus.src_data, e.sop, e.eop, e.data);
          end
          if (last_c >= 0 && c != last_c + 1) gaps++;
          last_c = c;
        end
      end
      if (done) begin
        done_c = c;
        n_tests++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_at_done got=%b required 0", busy);
        end
        break;
      end
    end
    n_tests++;
    if (done_c < 0) begin
      n_fail++; $display("FAIL done_timeout got no done required done within %0d cycles", budget);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_bytes got %0d left required 0", exp_q.size());
    end
    exp_q.delete();
    n_tests++;
    if (addr_log.size() != int'(len)) begin
      n_fail++; $display("FAIL read_count got=%0d required=%0d", addr_log.size(), len);
    end
    n_tests++;
    if (done_c != last_c + 1) begin
      n_fail++; $display("FAIL done_timing done=%0d required last_accept+1=%0d", done_c, last_c + 1);
    end
  endtask

  task automatic check_fast_run(input string tag, input int first_c, input int gaps,
                                input bit stall_seen);
    n_tests++;
    if (first_c != 3) begin
      n_fail++; $display("FAIL %s_first_valid got cycle %0d required 3", tag, first_c);
    end
    n_tests++;
    if (gaps != 0 || stall_seen) begin
      n_fail++; $display("FAIL %s_no_bubbles gaps=%0d stall=%b required 0/0", tag, gaps, stall_seen);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.mem_clken !== 1'b1) begin
      n_fail++; $display("FAIL clken_after_reset got=%b required 1", bus.mem_clken);
    end
  endtask

  task automatic test_basic;
    int f, l, d, g; bit s;
    stream_run(19'h00010, 19'd8, 0, f, l, d, g, s);
    check_fast_run("basic", f, g, s);
  endtask

  task automatic test_wrap;
    int f, l, d, g; bit s;
    logic [18:0] want [4];
    want[0] = 19'd409598; want[1] = 19'd409599; want[2] = 19'd0; want[3] = 19'd1;
    stream_run(19'd409598, 19'd4, 0, f, l, d, g, s);
    check_fast_run("wrap", f, g, s);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= addr_log.size() || addr_log[i] !== want[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d] got=%0d required=%0d", i,
                 (i < addr_log.size()) ? addr_log[i] : 19'h7FFFF, want[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int f, l, d, g; bit s;
    stream_run(19'h00100, 19'd16, 1, f, l, d, g, s);
    n_tests++;
    if (!s) begin
      n_fail++; $display("FAIL bp_cs_stall got stall=%b required 1", s);
    end
  endtask

  task automatic test_zero_length;
    bit activity;
    activity = 1'b0;
    addr_log.delete();
    @(negedge clk);
    start = 1'b1; start_addr = 19'h00200; length = 19'd0; bus.src_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.mem_chipselect || bus.src_valid || busy) activity = 1'b1;
      n_tests++;
      if (done !== (c == 1)) begin
        n_fail++; $display("FAIL zero_done cycle %0d got=%b required=%b", c, done, c == 1);
      end
    end
    n_tests++;
    if (activity || addr_log.size() != 0) begin
      n_fail++;
      $display("FAIL zero_activity got activity=%b reads=%0d required 0/0", activity, addr_log.size());
    end
  endtask

  task automatic test_abort;
    int f, l, d, g; bit s;
    @(negedge clk);
    start = 1'b1; start_addr = 19'h00400; length = 19'd100; bus.src_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin
        n_tests++;
        if (bus.src_valid !== 1'b1 || bus.src_sop !== 1'b1 || bus.src_data !== 8'h00) begin
          n_fail++;
          $display("FAIL abort_first_valid valid=%b sop=%b data=%h required 1/1/00",
                   bus.src_valid, bus.src_sop, bus.src_data);
        end
      end
      if (c == 5) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    n_tests++;
    if ({bus.src_valid, done, busy, bus.mem_chipselect} !== 4'b0100) begin
      n_fail++;
      $display("FAIL abort_response valid/done/busy/cs got=%b required 0100",
               {bus.src_valid, done, busy, bus.mem_chipselect});
    end
    @(negedge clk);
    n_tests++;
    if ({done, bus.src_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle done/valid/busy got=%b required 000", {done, bus.src_valid, busy});
    end
    stream_run(19'h00020, 19'd2, 0, f, l, d, g, s);
    check_fast_run("post_abort", f, g, s);
  endtask

  task automatic test_reset_mid_fetch;
    int f, l, d, g; bit s;
    @(negedge clk);
    start = 1'b1; start_addr = 19'h00050; length = 19'd50; bus.src_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    stream_run(19'h00030, 19'd3, 0, f, l, d, g, s);
    check_fast_run("post_reset", f, g, s);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; abort = 1'b0;
    bus.src_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_abort();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
